// File: rtl/axi4_lite_slave_regfile_if.sv
// rtl/axi4_lite_slave_regfile_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi4_lite_slave_regfile_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0]  S_AXI_AWADDR;
  logic                      S_AXI_AWVALID;
  logic                      S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                      S_AXI_WVALID;
  logic                      S_AXI_WREADY;
  logic [1:0]                S_AXI_BRESP;
  logic                      S_AXI_BVALID;
  logic                      S_AXI_BREADY;
  logic [ADDRESS_WIDTH-1:0]  S_AXI_ARADDR;
  logic                      S_AXI_ARVALID;
  logic                      S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                S_AXI_RRESP;
  logic                      S_AXI_RVALID;
  logic                      S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, input S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
    input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, input S_AXI_ARREADY,
    input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
  );

  modport slave (
    input S_AXI_AWADDR, S_AXI_AWVALID, output S_AXI_AWREADY,
    input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
    input S_AXI_ARADDR, S_AXI_ARVALID, output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, output S_AXI_RVALID, input S_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// rtl/axi4_lite_slave_regfile.sv - AXI4-Lite slave word register file (optional byte strobes via AXI_SLV_WSTRB_EN)
module axi4_lite_slave_regfile #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  axi4_lite_slave_regfile_if.slave s_axi
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WORD_W = ADDRESS_WIDTH - 2;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [WORD_W-1:0] NUM_REGS_W = WORD_W'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic              awready, wready, bvalid, arready, rvalid;
  logic              aw_hs, w_hs, ar_hs;
  logic [WORD_W-1:0] aw_word, ar_word, aw_word_q, commit_word;
  logic [DATA_WIDTH-1:0] wdata_q, commit_data, wr_word, rdata_q;
  logic [STRB_W-1:0] wstrb_q, commit_strb;
  logic [1:0]        bresp_q, rresp_q;
  logic              commit, commit_in_range, ar_in_range;
  logic [IDX_W-1:0]  commit_idx, ar_idx;

  assign aw_word = s_axi.S_AXI_AWADDR[ADDRESS_WIDTH-1:2];
  assign ar_word = s_axi.S_AXI_ARADDR[ADDRESS_WIDTH-1:2];
  assign aw_hs   = s_axi.S_AXI_AWVALID & awready;
  assign w_hs    = s_axi.S_AXI_WVALID & wready;
  assign ar_hs   = s_axi.S_AXI_ARVALID & arready;

  // The byte offset within a word is a don't-care, as are strobes when byte writes are off
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0], commit_strb};

  // Second handshake of a write: whichever half arrives last closes the transaction
  assign commit = ((w_state == W_IDLE) && aw_hs && w_hs) ||
                  ((w_state == W_WAIT_DATA) && w_hs) ||
                  ((w_state == W_WAIT_ADDR) && aw_hs);
  assign commit_word     = (w_state == W_WAIT_DATA) ? aw_word_q : aw_word;
  assign commit_data     = (w_state == W_WAIT_ADDR) ? wdata_q : s_axi.S_AXI_WDATA;
  assign commit_strb     = (w_state == W_WAIT_ADDR) ? wstrb_q : s_axi.S_AXI_WSTRB;
  assign commit_in_range = commit_word < NUM_REGS_W;
  assign commit_idx      = commit_word[IDX_W-1:0];
  assign ar_in_range     = ar_word < NUM_REGS_W;
  assign ar_idx          = ar_word[IDX_W-1:0];

  // Write FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // Write FSM next-state: accept address and data in either order or together
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_WAIT_DATA;
        else if (w_hs)     w_next = W_WAIT_ADDR;
      end
      W_WAIT_DATA: if (w_hs)  w_next = W_RESP;
      W_WAIT_ADDR: if (aw_hs) w_next = W_RESP;
      W_RESP:      if (s_axi.S_AXI_BREADY) w_next = W_IDLE;
      default:     w_next = W_IDLE;
    endcase
  end

  // Write FSM outputs; readies stay low while reset is held
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE:      begin awready = ~ARESET; wready = ~ARESET; end
      W_WAIT_DATA: wready  = ~ARESET;
      W_WAIT_ADDR: awready = ~ARESET;
      W_RESP:      bvalid  = 1'b1;
      default:     ;
    endcase
  end

  // Latch the early half of a split write and record the response at commit
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_word_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if ((w_state == W_IDLE) && aw_hs && !w_hs) aw_word_q <= aw_word;
      if ((w_state == W_IDLE) && w_hs && !aw_hs) begin
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
      if (commit) bresp_q <= commit_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Word to store: either the full bus word or a byte-wise merge with the current contents
  always_comb begin
    wr_word = commit_data;
`ifdef AXI_SLV_WSTRB_EN
    wr_word = regs[commit_idx];
    for (int b = 0; b < STRB_W; b++) begin
      if (commit_strb[b]) wr_word[8*b +: 8] = commit_data[8*b +: 8];
    end
`endif
  end

  // Register array; out-of-range commits leave it untouched
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && commit_in_range) begin
      regs[commit_idx] <= wr_word;
    end
  end

  // Read FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // Read FSM next-state
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (s_axi.S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    arready = (r_state == R_IDLE) & ~ARESET;
    rvalid  = (r_state == R_DATA);
  end

  // Read data captured at the AR handshake; a same-edge write is not yet visible
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      if (ar_in_range) begin
        rdata_q <= regs[ar_idx];
        rresp_q <= RESP_OKAY;
      end else begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb/tb_axi4_lite_slave_regfile.sv - directed bench for axi4_lite_slave_regfile
module tb_axi4_lite_slave_regfile;

  logic ACLK;
  logic ARESET;
  int   vectors;
  int   miscompares;

  axi4_lite_slave_regfile_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave_regfile #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .s_axi  (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic write_same(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] resp, input string tag);
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    check({tag, "_awready"}, 32'(bus.S_AXI_AWREADY), 32'd1);
    check({tag, "_wready"},  32'(bus.S_AXI_WREADY),  32'd1);
    tick;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check({tag, "_bvalid"}, 32'(bus.S_AXI_BVALID), 32'd1);
    check({tag, "_bresp"},  32'(bus.S_AXI_BRESP),  32'(resp));
    tick;
    check({tag, "_bvalid_drop"}, 32'(bus.S_AXI_BVALID), 32'd0);
  endtask

  task automatic read_chk(input logic [31:0] a, input logic [31:0] exp,
                          input logic [1:0] resp, input string tag);
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    check({tag, "_arready"}, 32'(bus.S_AXI_ARREADY), 32'd1);
    tick;
    bus.S_AXI_ARVALID = 1'b0;
    check({tag, "_rvalid"}, 32'(bus.S_AXI_RVALID), 32'd1);
    check({tag, "_rdata"},  bus.S_AXI_RDATA, exp);
    check({tag, "_rresp"},  32'(bus.S_AXI_RRESP), 32'(resp));
    tick;
    check({tag, "_rvalid_drop"}, 32'(bus.S_AXI_RVALID), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ARESET = 1'b1;
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;

    // reset state
    #1;
    check("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("rst_wready",  32'(bus.S_AXI_WREADY),  32'd0);
    check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    check("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    check("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    check("rst_rdata",   bus.S_AXI_RDATA,        32'd0);
    tick;
    tick;
    ARESET = 1'b0;
    #1;
    check("post_rst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("post_rst_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    tick;

    // simultaneous AW+W, then read back
    write_same(32'h08, 32'hDEADBEEF, 4'hF, 2'b00, "w08");
    read_chk(32'h08, 32'hDEADBEEF, 2'b00, "r08");

    // address two cycles ahead of data
    bus.S_AXI_AWADDR  = 32'h04;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    check("aw_first_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    tick;
    bus.S_AXI_AWVALID = 1'b0;
    check("wait_data_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("wait_data_wready",  32'(bus.S_AXI_WREADY),  32'd1);
    check("wait_data_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    tick;
    check("wait_data_awready2", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("wait_data_bvalid2",  32'(bus.S_AXI_BVALID),  32'd0);
    bus.S_AXI_WDATA  = 32'h12345678;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    tick;
    bus.S_AXI_WVALID = 1'b0;
    check("aw_first_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    check("aw_first_bresp",  32'(bus.S_AXI_BRESP),  32'd0);
    tick;
    check("aw_first_bvalid_drop", 32'(bus.S_AXI_BVALID), 32'd0);
    read_chk(32'h04, 32'h12345678, 2'b00, "r04");

    // data ahead of address
    bus.S_AXI_WDATA  = 32'hA5A55A5A;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    tick;
    bus.S_AXI_WVALID = 1'b0;
    check("wait_addr_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("wait_addr_wready",  32'(bus.S_AXI_WREADY),  32'd0);
    bus.S_AXI_AWADDR  = 32'h0C;
    bus.S_AXI_AWVALID = 1'b1;
    tick;
    bus.S_AXI_AWVALID = 1'b0;
    check("w_first_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    tick;
    read_chk(32'h0C, 32'hA5A55A5A, 2'b00, "r0c");

    // out of range: index 16 must not alias onto index 0
    write_same(32'h40, 32'hBAD0BAD0, 4'hF, 2'b10, "w40");
    read_chk(32'h40, 32'h0, 2'b10, "r40");
    read_chk(32'h00, 32'h0, 2'b00, "r00_after_oor");
    read_chk(32'h08, 32'hDEADBEEF, 2'b00, "r08_after_oor");

    // low address bits ignored
    write_same(32'h13, 32'h11112222, 4'hF, 2'b00, "w13");
    read_chk(32'h10, 32'h11112222, 2'b00, "r10");

    // byte strobes
    write_same(32'h00, 32'hFFFFFFFF, 4'hF, 2'b00, "w00_ones");
    write_same(32'h00, 32'h00000000, 4'h3, 2'b00, "w00_strb3");
`ifdef AXI_SLV_WSTRB_EN
    read_chk(32'h00, 32'hFFFF0000, 2'b00, "r00_strb3");
    write_same(32'h00, 32'h12345678, 4'h0, 2'b00, "w00_strb0");
    read_chk(32'h00, 32'hFFFF0000, 2'b00, "r00_strb0");
`else
    read_chk(32'h00, 32'h00000000, 2'b00, "r00_strb3");
    write_same(32'h00, 32'h12345678, 4'h0, 2'b00, "w00_strb0");
    read_chk(32'h00, 32'h12345678, 2'b00, "r00_strb0");
`endif

    // write commit and read of the same register on one edge
    bus.S_AXI_AWADDR  = 32'h08;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = 32'hCAFEF00D;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_ARADDR  = 32'h08;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    tick;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    check("coll_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    check("coll_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    check("coll_rdata",  bus.S_AXI_RDATA, 32'hDEADBEEF);
    tick;
    read_chk(32'h08, 32'hCAFEF00D, 2'b00, "r08_after_coll");

    // write response backpressure
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_AWADDR  = 32'h14;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = 32'h00000055;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_WVALID  = 1'b1;
    tick;
    bus.S_AXI_AWADDR = 32'h18;
    bus.S_AXI_WDATA  = 32'h99999999;
    for (int i = 0; i < 5; i++) begin
      check("bp_w_bvalid",  32'(bus.S_AXI_BVALID),  32'd1);
      check("bp_w_bresp",   32'(bus.S_AXI_BRESP),   32'd0);
      check("bp_w_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
      check("bp_w_wready",  32'(bus.S_AXI_WREADY),  32'd0);
      tick;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    check("bp_w_bvalid_last", 32'(bus.S_AXI_BVALID), 32'd1);
    tick;
    check("bp_w_bvalid_drop", 32'(bus.S_AXI_BVALID), 32'd0);
    read_chk(32'h18, 32'h0, 2'b00, "r18_not_written");

    // read data backpressure
    bus.S_AXI_RREADY  = 1'b0;
    bus.S_AXI_ARADDR  = 32'h14;
    bus.S_AXI_ARVALID = 1'b1;
    tick;
    bus.S_AXI_ARADDR = 32'h40;
    for (int i = 0; i < 5; i++) begin
      check("bp_r_rvalid",  32'(bus.S_AXI_RVALID),  32'd1);
      check("bp_r_rdata",   bus.S_AXI_RDATA,        32'h00000055);
      check("bp_r_rresp",   32'(bus.S_AXI_RRESP),   32'd0);
      check("bp_r_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
      tick;
    end
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
    tick;
    check("bp_r_rvalid_drop", 32'(bus.S_AXI_RVALID), 32'd0);

    // reset while waiting for write data
    bus.S_AXI_AWADDR  = 32'h14;
    bus.S_AXI_AWVALID = 1'b1;
    tick;
    bus.S_AXI_AWVALID = 1'b0;
    check("mid_wait_data_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    ARESET = 1'b1;
    #1;
    check("mid_rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("mid_rst_wready",  32'(bus.S_AXI_WREADY),  32'd0);
    check("mid_rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    check("mid_rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    check("mid_rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    check("mid_rst_rdata",   bus.S_AXI_RDATA,        32'd0);
    check("mid_rst_bresp",   32'(bus.S_AXI_BRESP),   32'd0);
    tick;
    ARESET = 1'b0;
    #1;
    check("post_mid_rst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("post_mid_rst_wready",  32'(bus.S_AXI_WREADY),  32'd1);
    tick;
    read_chk(32'h14, 32'h0, 2'b00, "r14_after_rst");
    read_chk(32'h08, 32'h0, 2'b00, "r08_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
